nibble_packer: RTL

- Receiving end of the 4-bit nibble pipelines driven by the BLK/NBLK stimulus benches.
- Accepts a stream of DW-bit values with a valid/ready handshake and packs NUM consecutive values into one word.
- Presents each packed word through a one-entry output buffer with its own valid/ready handshake.
- Sits downstream of any nibble-wide shift/delay stage; lets the bench or a consumer read whole words instead of per-cycle nibbles.

---
 rtl/nibble_pkg.sv | 25 ++
 rtl/nibble_packer_if.sv | 27 ++
 rtl/nibble_packer_word_hold_buf.sv | 36 +++
 rtl/nibble_packer.sv | 84 ++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared constants, FSM encoding and slice-placement helper for the nibble
// packer family.
package nibble_pkg;

    localparam int DW_DEF  = 4;
    localparam int NUM_DEF = 4;
    localparam int FILL_W  = $clog2(NUM_DEF);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    // Lowest bit index of the slice that receives the k-th value of a word.
    function automatic int slot_lo(input int k, input int dw, input int num, input bit msb_first);
        int lo;
        if (msb_first) begin
            lo = dw * (num - 1 - k);
        end else begin
            lo = dw * k;
        end
        return lo;
    endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Input and output valid/ready channels of the nibble packer, plus the
// partial-word discard and fill level.
interface nibble_packer_if
    import nibble_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int NUM = NUM_DEF
);
    logic                     clear;
    logic                     in_valid;
    logic [DW-1:0]            in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [DW*NUM-1:0]        out_data;
    logic                     out_ready;
    logic [$clog2(NUM)-1:0]   fill;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, fill
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, fill
    );
endinterface

// File: rtl/nibble_packer_word_hold_buf.sv
// One-entry valid/ready output buffer; a load replaces the held word even on
// the edge where the old one is consumed, so there is no bubble.
module word_hold_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Buffer occupancy and held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/nibble_packer.sv
// Packs NUM consecutive DW-bit values into one word and hands it to a
// one-entry output buffer.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NUM       = NUM_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    nibble_packer_if.slave   bus
);

    localparam int             FW   = $clog2(NUM);
    localparam int             WW   = DW * NUM;
    localparam logic [FW-1:0]  LAST = FW'(NUM - 1);

    logic [FW-1:0] r_fill;
    state_t        r_state;
    logic [WW-1:0] r_pack;
    logic [WW-1:0] w_word;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_complete;
    logic          w_buf_valid;

    // The final slot waits for room in the buffer; out_ready feeds straight
    // through so a consume and a completion can share an edge.
    assign w_in_ready = rst_n && ((r_fill != LAST) || !w_buf_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready && !bus.clear;
    assign w_complete = w_accept && (r_state == FILLING) && (r_fill == LAST);

    // Current partial word with the incoming value dropped into its slot.
    always_comb begin
        w_word = r_pack;
        for (int k = 0; k < NUM; k++) begin
            w_word[slot_lo(k, DW, NUM, MSB_FIRST) +: DW] =
                (FW'(k) == r_fill) ? bus.in_data : r_pack[slot_lo(k, DW, NUM, MSB_FIRST) +: DW];
        end
    end

    // Fill counter, pack register and EMPTY/FILLING state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_pack  <= '0;
            r_state <= EMPTY;
        end else if (bus.clear) begin
            r_fill  <= '0;
            r_pack  <= '0;
            r_state <= EMPTY;
        end else if (w_complete) begin
            r_fill  <= '0;
            r_pack  <= '0;
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_fill  <= r_fill + FW'(1);
            r_pack  <= w_word;
            r_state <= FILLING;
        end else begin
            r_fill  <= r_fill;
            r_pack  <= r_pack;
            r_state <= r_state;
        end
    end

    word_hold_buf #(
        .W (WW)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_complete),
        .i_data  (w_word),
        .i_ready (bus.out_ready),
        .o_valid (w_buf_valid),
        .o_data  (bus.out_data)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_buf_valid;
    assign bus.fill      = r_fill;

endmodule
